// File: rtl/vproc_pkg.sv
// vproc_pkg: types and constants shared by the vector coprocessor host-side blocks.
package vproc_pkg;

    // Largest ID width that fits host_result_t; users narrow the id field to their own XIF_ID_W.
    localparam int unsigned XIF_ID_MAX_W = 8;

    localparam logic [4:0] XREG_ZERO = 5'd0;

    typedef struct packed {
        logic [XIF_ID_MAX_W-1:0] id;
        logic [31:0]             data;
        logic [4:0]              rd;
        logic                    we;
        logic                    exc;
        logic [5:0]              exccode;
    } host_result_t;

endpackage

// File: rtl/vproc_host_result_buf.sv
// vproc_host_result_buf: one-entry XIF result buffer that drains once the
// buffered result no longer needs the shared regfile port, or the port is free.
module vproc_host_result_buf
    import vproc_pkg::*;
(
    input  logic         clk_i,
    input  logic         async_rst_ni,
    input  logic         in_valid,
    output logic         in_ready,
    input  host_result_t in_data,
    input  logic         core_wb_valid,
    output logic         drain,
    output host_result_t buf_data
);

    logic         valid_q;
    host_result_t data_q;

    // Only a genuine register write has to wait for the core's writeback to vacate the port.
    assign drain    = valid_q & (data_q.exc | ~data_q.we | (data_q.rd == XREG_ZERO) | ~core_wb_valid);
    assign in_ready = ~valid_q | drain;
    assign buf_data = data_q;

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/vproc_host_result.sv
// vproc_host_result: host-side XIF result receiver with outstanding-ID table and busy flags.
// Optional sticky protocol checker on err_o: define VPROC_HOST_RESULT_CHECK_EN.
module vproc_host_result
    import vproc_pkg::*;
#(
    parameter int unsigned XIF_ID_W       = 3,
    parameter logic        DONT_CARE_ZERO = 1'b0
) (
    input  logic                clk_i,
    input  logic                async_rst_ni,
    input  logic                issue_valid_i,
    input  logic [XIF_ID_W-1:0] issue_id_i,
    input  logic                issue_we_i,
    input  logic [4:0]          issue_rd_i,
    input  logic                result_valid_i,
    output logic                result_ready_o,
    input  logic [XIF_ID_W-1:0] result_id_i,
    input  logic [31:0]         result_data_i,
    input  logic [4:0]          result_rd_i,
    input  logic                result_we_i,
    input  logic                result_exc_i,
    input  logic [5:0]          result_exccode_i,
    input  logic                core_wb_valid_i,
    output logic                rf_we_o,
    output logic [4:0]          rf_addr_o,
    output logic [31:0]         rf_data_o,
    output logic                exc_valid_o,
    output logic [XIF_ID_W-1:0] exc_id_o,
    output logic [5:0]          exc_code_o,
    output logic [31:0]         rd_busy_o,
    output logic                err_o
);

    localparam int unsigned NUM_IDS = 1 << XIF_ID_W;

    localparam logic [31:0]         DC_DATA = DONT_CARE_ZERO ? '0 : 'x;
    localparam logic [4:0]          DC_RD   = DONT_CARE_ZERO ? '0 : 'x;
    localparam logic [5:0]          DC_CODE = DONT_CARE_ZERO ? '0 : 'x;
    localparam logic [XIF_ID_W-1:0] DC_ID   = DONT_CARE_ZERO ? '0 : 'x;

    host_result_t in_res, buf_res;
    logic         drain;
    logic [XIF_ID_W-1:0] buf_id;

    logic [NUM_IDS-1:0]      pending_q, we_q;
    logic [NUM_IDS-1:0][4:0] rd_q;

    always_comb begin
        in_res         = '0;
        in_res.id      = XIF_ID_MAX_W'(result_id_i);
        in_res.data    = result_data_i;
        in_res.rd      = result_rd_i;
        in_res.we      = result_we_i;
        in_res.exc     = result_exc_i;
        in_res.exccode = result_exccode_i;
    end

    vproc_host_result_buf u_buf (
        .clk_i         (clk_i),
        .async_rst_ni  (async_rst_ni),
        .in_valid      (result_valid_i),
        .in_ready      (result_ready_o),
        .in_data       (in_res),
        .core_wb_valid (core_wb_valid_i),
        .drain         (drain),
        .buf_data      (buf_res)
    );

    assign buf_id = buf_res.id[XIF_ID_W-1:0];

    if (XIF_ID_W < XIF_ID_MAX_W) begin : g_id_hi
        logic unused_id_hi;
        assign unused_id_hi = ^buf_res.id[XIF_ID_MAX_W-1:XIF_ID_W];
    end

    assign rf_we_o     = drain & buf_res.we & ~buf_res.exc & (buf_res.rd != XREG_ZERO);
    assign rf_addr_o   = rf_we_o ? buf_res.rd : DC_RD;
    assign rf_data_o   = rf_we_o ? buf_res.data : DC_DATA;
    assign exc_valid_o = drain & buf_res.exc;
    assign exc_id_o    = exc_valid_o ? buf_id : DC_ID;
    assign exc_code_o  = exc_valid_o ? buf_res.exccode : DC_CODE;

    // Issue is written after retire so a same-cycle reuse of an ID leaves it pending.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            pending_q <= '0;
            we_q      <= '0;
            rd_q      <= '0;
        end else begin
            if (drain) begin
                pending_q[buf_id] <= 1'b0;
            end
            if (issue_valid_i) begin
                pending_q[issue_id_i] <= 1'b1;
                we_q[issue_id_i]      <= issue_we_i;
                rd_q[issue_id_i]      <= issue_rd_i;
            end
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int unsigned i = 0; i < NUM_IDS; i++) begin
            if (pending_q[i[XIF_ID_W-1:0]] && we_q[i[XIF_ID_W-1:0]]) begin
                rd_busy_o[rd_q[i[XIF_ID_W-1:0]]] = 1'b1;
            end
        end
        rd_busy_o[0] = 1'b0;
    end

`ifdef VPROC_HOST_RESULT_CHECK_EN
    logic accept, err_unknown, err_rd, err_reissue, err_q;

    assign accept      = result_valid_i & result_ready_o;
    assign err_unknown = accept & ~pending_q[result_id_i];
    assign err_rd      = accept & result_we_i
                         & (~we_q[result_id_i] | (rd_q[result_id_i] != result_rd_i));
    assign err_reissue = issue_valid_i & pending_q[issue_id_i] & ~(drain & (buf_id == issue_id_i));

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            err_q <= 1'b0;
        end else if (err_unknown | err_rd | err_reissue) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_vproc_host_result.sv
// Self-checking bench for vproc_host_result: directed scenarios plus random traffic
// compared against a transaction-level model of the outstanding table and result buffer.
module tb_vproc_host_result;

    localparam int unsigned IDW  = 3;
    localparam int unsigned NIDS = 1 << IDW;
`ifdef VPROC_HOST_RESULT_CHECK_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           iv, iwe, rv, rready, rwe, rexc, wb;
    logic [IDW-1:0] iid, rid, exc_id;
    logic [4:0]     ird, rrd, rf_addr;
    logic [31:0]    rdata, rf_data, busy;
    logic [5:0]     rcode, exc_code;
    logic           rf_we, exc_v, err;

    always #5 clk = ~clk;

    vproc_host_result #(
        .XIF_ID_W       (IDW),
        .DONT_CARE_ZERO (1'b1)
    ) dut (
        .clk_i            (clk),
        .async_rst_ni     (rst_n),
        .issue_valid_i    (iv),
        .issue_id_i       (iid),
        .issue_we_i       (iwe),
        .issue_rd_i       (ird),
        .result_valid_i   (rv),
        .result_ready_o   (rready),
        .result_id_i      (rid),
        .result_data_i    (rdata),
        .result_rd_i      (rrd),
        .result_we_i      (rwe),
        .result_exc_i     (rexc),
        .result_exccode_i (rcode),
        .core_wb_valid_i  (wb),
        .rf_we_o          (rf_we),
        .rf_addr_o        (rf_addr),
        .rf_data_o        (rf_data),
        .exc_valid_o      (exc_v),
        .exc_id_o         (exc_id),
        .exc_code_o       (exc_code),
        .rd_busy_o        (busy),
        .err_o            (err)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference state: issued instructions, the one held result, sticky error.
    bit          m_pend[NIDS];
    bit          m_we[NIDS];
    logic [4:0]  m_rd[NIDS];
    bit          h_v, h_we, h_exc;
    logic [IDW-1:0] h_id;
    logic [31:0] h_data;
    logic [4:0]  h_rd;
    logic [5:0]  h_code;
    bit          m_err;
    bit          exp_ready, last_acc;
    bit          sent[NIDS];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int unsigned i = 0; i < NIDS; i++) begin
            m_pend[i] = 1'b0; m_we[i] = 1'b0; m_rd[i] = '0; sent[i] = 1'b0;
        end
        h_v = 1'b0; m_err = 1'b0; last_acc = 1'b0;
    endtask

    task automatic idle_inputs();
        iv = 0; iid = '0; iwe = 0; ird = '0;
        rv = 0; rid = '0; rdata = '0; rrd = '0; rwe = 0; rexc = 0; rcode = '0;
        wb = 0;
    endtask

    task automatic set_iss(input logic v, input logic [IDW-1:0] id, input logic we, input logic [4:0] rd);
        iv = v; iid = id; iwe = we; ird = rd;
    endtask

    task automatic set_res(input logic v, input logic [IDW-1:0] id, input logic [31:0] d,
                           input logic [4:0] rd, input logic we, input logic exc, input logic [5:0] code);
        rv = v; rid = id; rdata = d; rrd = rd; rwe = we; rexc = exc; rcode = code;
    endtask

    // Called at posedge+2 with inputs applied; checks outputs, crosses one edge, updates model.
    task automatic cycle();
        bit done, e_we, e_exc, accept;
        logic [31:0] eb;
        #2;
        done  = h_v && (h_exc || !h_we || h_rd == 5'd0 || !wb);
        e_we  = done && h_we && !h_exc && h_rd != 5'd0;
        e_exc = done && h_exc;
        exp_ready = !h_v || done;
        eb = '0;
        for (int unsigned i = 0; i < NIDS; i++)
            if (m_pend[i] && m_we[i]) eb[m_rd[i]] = 1'b1;
        eb[0] = 1'b0;
        check_eq("ready", rready, exp_ready);
        check_eq("rf_we", rf_we, e_we);
        check_eq("rf_addr", rf_addr, e_we ? h_rd : 5'd0);
        check_eq("rf_data", rf_data, e_we ? h_data : 32'd0);
        check_eq("exc_valid", exc_v, e_exc);
        check_eq("exc_id", exc_id, e_exc ? h_id : '0);
        check_eq("exc_code", exc_code, e_exc ? h_code : 6'd0);
        check_eq("rd_busy", busy, eb);
        check_eq("err", err, ERR_EN ? m_err : 1'b0);
        @(posedge clk);
        accept = rv && exp_ready;
        if (accept && !m_pend[rid]) m_err = 1'b1;
        if (accept && rwe && (!m_we[rid] || m_rd[rid] != rrd)) m_err = 1'b1;
        if (iv && m_pend[iid] && !(done && h_id == iid)) m_err = 1'b1;
        if (done) m_pend[h_id] = 1'b0;
        if (iv) begin
            m_pend[iid] = 1'b1; m_we[iid] = iwe; m_rd[iid] = ird; sent[iid] = 1'b0;
        end
        if (accept) begin
            h_v = 1'b1; h_id = rid; h_data = rdata; h_rd = rrd;
            h_we = rwe; h_exc = rexc; h_code = rcode;
        end else if (done) begin
            h_v = 1'b0;
        end
        last_acc = accept;
        #2;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, rready, 1'b1);
        check_eq({tag, "_rf_we"}, rf_we, 1'b0);
        check_eq({tag, "_rf_addr"}, rf_addr, 5'd0);
        check_eq({tag, "_exc"}, exc_v, 1'b0);
        check_eq({tag, "_busy"}, busy, 32'd0);
        check_eq({tag, "_err"}, err, 1'b0);
    endtask

    // Entered and left at posedge+2; reset is asserted between edges.
    task automatic reset_mid();
        #1 rst_n = 1'b0;
        idle_inputs();
        #1 check_reset_vals("rst_mid");
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic random_phase(input int unsigned n);
        int unsigned start, c;
        bit found;
        for (int unsigned k = 0; k < n; k++) begin
            if (!rv || last_acc) begin
                rv = 1'b0;
                if ($urandom_range(3) != 0) begin
                    start = $urandom_range(NIDS - 1);
                    found = 1'b0;
                    for (int unsigned j = 0; j < NIDS && !found; j++) begin
                        c = (start + j) % NIDS;
                        if (m_pend[c] && !sent[c]) found = 1'b1;
                    end
                    if (found) begin
                        set_res(1'b1, IDW'(c), $urandom, m_rd[c], m_we[c] && ($urandom_range(4) != 0),
                                $urandom_range(7) == 0, 6'($urandom_range(63)));
                        sent[c] = 1'b1;
                    end
                end
            end
            iv = 1'b0;
            if ($urandom_range(1) == 1) begin
                c = $urandom_range(NIDS - 1);
                if (!m_pend[c]) set_iss(1'b1, IDW'(c), $urandom_range(3) != 0, 5'($urandom_range(31)));
            end
            wb = ($urandom_range(2) == 0);
            cycle();
        end
        // Let any held result drain before leaving the phase.
        rv = 1'b0; iv = 1'b0; wb = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #2 check_reset_vals("rst");
        rst_n = 1'b1;

        // Issue then result with a free port: write on the next cycle.
        set_iss(1, 3'd2, 1, 5'd5); cycle();
        set_iss(0, '0, 0, '0);
        set_res(1, 3'd2, 32'hDEADBEEF, 5'd5, 1, 0, 6'd0);
        #2 check_eq("t1_busy5_set", busy[5], 1'b1);
        cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        #2 check_eq("t1_wdata", rf_data, 32'hDEADBEEF);
        cycle();
        #2 check_eq("t1_busy5_clr", busy[5], 1'b0);
        cycle();

        // Same, with the core holding the port for three cycles.
        set_iss(1, 3'd2, 1, 5'd5); cycle();
        set_iss(0, '0, 0, '0);
        set_res(1, 3'd2, 32'h1234_5678, 5'd5, 1, 0, 6'd0); cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        wb = 1;
        repeat (3) begin
            #2 check_eq("t2_stall_ready", rready, 1'b0);
            cycle();
        end
        wb = 0;
        #2 check_eq("t2_write", rf_we, 1'b1);
        cycle();

        // Out-of-order back-to-back results.
        for (int unsigned i = 0; i < 3; i++) begin
            set_iss(1, IDW'(i), 1, 5'(i + 1)); cycle();
        end
        set_iss(0, '0, 0, '0);
        set_res(1, 3'd2, 32'hA2, 5'd3, 1, 0, '0); cycle();
        set_res(1, 3'd0, 32'hA0, 5'd1, 1, 0, '0); cycle();
        set_res(1, 3'd1, 32'hA1, 5'd2, 1, 0, '0); cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        repeat (2) cycle();
        check_eq("t3_busy_end", busy, 32'd0);

        // Exception result.
        set_iss(1, 3'd3, 1, 5'd9); cycle();
        set_iss(0, '0, 0, '0);
        set_res(1, 3'd3, 32'hFFFF, 5'd9, 1, 1, 6'd13); cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        #2 check_eq("t4_exc_code", exc_code, 6'd13);
        check_eq("t4_no_write", rf_we, 1'b0);
        cycle();
        #2 check_eq("t4_pulse_end", exc_v, 1'b0);
        cycle();

        // Retire and reissue id 1 in the same cycle.
        set_iss(1, 3'd1, 1, 5'd4); cycle();
        set_iss(0, '0, 0, '0);
        set_res(1, 3'd1, 32'h44, 5'd4, 1, 0, '0); cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        set_iss(1, 3'd1, 1, 5'd7); cycle();
        set_iss(0, '0, 0, '0);
        #2 check_eq("t5_busy7", busy[7], 1'b1);
        check_eq("t5_busy4", busy[4], 1'b0);
        cycle();

        // Result for an ID that was never issued.
        set_res(1, 3'd4, 32'h55, 5'd10, 1, 0, '0); cycle();
        set_res(0, '0, '0, '0, 0, 0, '0);
        repeat (3) cycle();
        check_eq("t6_err_held", err, ERR_EN);

        random_phase(300);
        reset_mid();
        random_phase(200);
        reset_mid();
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/vproc_host_result.md
Name: vproc_host_result

Overview:
Host-side receiver for the XIF result channel. It is the far end of the coprocessor result transmitter. It accepts result transactions from the vector coprocessor into a one-entry buffer and tracks outstanding offloaded instruction IDs. Results are written into the host integer register file through a write port shared with the core's own writeback, which has priority; exceptions are reported to the host controller. Per-register busy flags let the host stall dependent instructions.

Parameters:
XIF_ID_W, 3, width in bits of instruction IDs; the outstanding table has 2**XIF_ID_W entries
DONT_CARE_ZERO, 1'b0, drive don't-care output values to zero instead of 'x

Ports:
clk_i  input  1  clock
async_rst_ni  input  1  asynchronous active-low reset
issue_valid_i  input  1  host commits an offloaded instruction this cycle
issue_id_i  input  XIF_ID_W  ID of the committed instruction
issue_we_i  input  1  instruction will write an x register
issue_rd_i  input  5  destination x register
result_valid_i  input  1  XIF result valid from coprocessor
result_ready_o  output  1  XIF result ready to coprocessor
result_id_i  input  XIF_ID_W  result ID
result_data_i  input  32  result data
result_rd_i  input  5  result destination register
result_we_i  input  1  result writes rd
result_exc_i  input  1  result carries an exception
result_exccode_i  input  6  exception code
core_wb_valid_i  input  1  core's own writeback uses the regfile port this cycle
rf_we_o  output  1  regfile write enable for a coprocessor result
rf_addr_o  output  5  regfile write address
rf_data_o  output  32  regfile write data
exc_valid_o  output  1  one-cycle exception pulse
exc_id_o  output  XIF_ID_W  ID of the faulting instruction
exc_code_o  output  6  exception code
rd_busy_o  output  32  bit r set while any pending ID will write x register r (bit 0 always 0)
err_o  output  1  sticky protocol error (optional feature)

Behaviour:
- Reset values: buffer empty; all pending bits 0; result_ready_o=1; rf_we_o=0; exc_valid_o=0; rd_busy_o=0; err_o=0. Non-valid data outputs are 0 if DONT_CARE_ZERO, otherwise 'x.
- Issue: issue_valid_i sets pending[id], and stores we[id] and rd[id] from the issue fields.
- Accept: a result transfers when result_valid_i & result_ready_o, and is latched into the buffer (buf_valid_q=1).
- result_ready_o = ~buf_valid_q | drain. It never depends on result_valid_i.
- drain = buf_valid_q & (buf_exc | ~buf_we | buf_rd==0 | ~core_wb_valid_i).
- Writeback: when drain & buf_we & ~buf_exc & buf_rd!=0, then rf_we_o=1, rf_addr_o=buf_rd, rf_data_o=buf_data. rf_we_o is never asserted while core_wb_valid_i=1.
- Exception: when drain & buf_exc, exc_valid_o=1 with the buffered ID and code. No regfile write takes place.
- Retire: on drain, clear pending[buf_id].
- Latency: a result accepted in cycle N writes back or raises its exception in cycle N+1 if the port is free. Each cycle the port is held by the core adds one cycle of stall.
- Back-to-back results: buffer refills in the same cycle it drains, sustaining one result per cycle.
- Busy flags: rd_busy_o = OR over pending IDs with we[id]=1 of onehot(rd[id]). A bit clears in the cycle after its retire.
- Simultaneous issue and retire of the same ID: clear first, then set, so the ID ends pending with the new rd and we.
- Results may arrive in any order. No ordering is enforced.
- Reset mid-operation discards the buffered result and all pending state.

Optional Feature:
VPROC_HOST_RESULT_CHECK_EN:
- Enabled: err_o is set and held until reset when any of these occur:
  - a result is accepted for an ID that is not pending;
  - an accepted result has we=1 but its rd differs from the issued rd or the issued we=0;
  - an issue targets an ID that is already pending and not retiring that cycle.
  The result is still processed normally.
- Disabled: err_o is tied to 0 and none of the comparison logic is built.

Decomposition:
- Shared vproc_pkg holds:
  - typedef host_result_t as a packed struct {id, data, rd, we, exc, exccode}, parameterised by the ID width through the struct users;
  - constant XREG_ZERO = 5'd0.
- One natural sub-module: vproc_host_result_buf, the one-entry buffer with valid/ready and drain. The top level holds the outstanding table, busy-flag generation and checks.

Test Plan:
1. Issue id=2 rd=5 we=1, then result id=2 rd=5 data=32'hDEADBEEF with core_wb_valid_i=0 -> next cycle rf_we_o=1, addr=5, data=DEADBEEF; rd_busy_o[5] 1 -> 0.
2. Same as test 1 but core_wb_valid_i=1 for 3 cycles -> rf_we_o held 0 and result_ready_o=0 for 3 cycles; write occurs in the 4th cycle.
3. Issue ids 0,1,2 (rd 1,2,3); results arrive 2,0,1 back-to-back -> three consecutive writes, one per cycle; result_ready_o stays 1; rd_busy_o ends 0.
4. Result id=3 exc=1 exccode=6'd13 -> exc_valid_o one-cycle pulse with id=3, code=13; no rf_we_o; pending[3] cleared.
5. Retire id=1 and issue id=1 rd=7 in the same cycle -> pending[1]=1 and rd_busy_o[7]=1 afterwards.
6. With VPROC_HOST_RESULT_CHECK_EN, send a result for non-pending id=4 -> err_o=1 from the next cycle, held until reset; assert async_rst_ni mid-stream -> all outputs return to reset values.
